nway_cache_array: RTL
=====================

Name: nway_cache_array

Overview:
- Parametrised N-way set-associative cache tag/data array with true-LRU replacement, per-line valid/dirty state and a bulk-invalidate sequencer.
- Sits between the L1 controller FSM and the memory interface.
- Accepts one lookup/write/fill/invalidate request per cycle and returns a registered response one cycle later.
- On misses and fills, the response carries hit status, hit way and victim information for writeback.

Parameters:
WAYS, 2, associativity; power of 2, range 2..8
SETS, 32, number of sets; power of 2
ADDR_W, 14, line-address width; index = low log2(SETS) bits, tag = remaining bits
DATA_W, 64, line data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request can be accepted this cycle
req_op  in  2  0=READ, 1=WRITE, 2=FILL, 3=INVAL_ALL
req_addr  in  ADDR_W  line address
req_wdata  in  DATA_W  write/fill data
req_dirty  in  1  dirty bit to store on FILL
rsp_valid  out  1  response valid, exactly one cycle per accepted request
rsp_hit  out  1  tag matched in a valid way
rsp_way  out  log2(WAYS)  hit way, or the way chosen/written on a miss or FILL
rsp_rdata  out  DATA_W  hit-way data (READ hit); otherwise 0
rsp_victim_dirty  out  1  victim valid AND dirty
rsp_victim_tag  out  ADDR_W-log2(SETS)  victim tag
rsp_victim_data  out  DATA_W  victim data

Behaviour:
- Reset (asynchronous):
  - All valid and dirty bits cleared.
  - LRU ages per set: age[w] = WAYS-1-w, so way 0 is LRU.
  - FSM goes to IDLE; req_ready=1.
  - All rsp_* outputs = 0.
  - Data and tag arrays are not reset.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- State timing: array, valid, dirty and LRU state update at the accepting edge.
- Response timing:
  - rsp_* register at the same accepting edge from pre-update state; rsp_valid is high the following cycle.
  - rsp_valid=0 on all other cycles.
- Back-to-back requests to the same set see the prior request's update; there is no stall.
- Victim selection:
  - Lowest-index invalid way, if any.
  - Otherwise the way with age WAYS-1.
- Hit: a way is a hit when it is valid and its stored tag equals req_addr's tag. At most one way may hit.
- LRU update on touching way w with old age a:
  - age[w]=0.
  - Each way with age < a increments.
  - Ages in a set always form a permutation of 0..WAYS-1.
- READ hit: rsp_hit=1, rsp_way=hit way, rsp_rdata=line data; touch hit way.
- READ miss:
  - rsp_hit=0; rsp_way=victim; victim fields report the victim line.
  - No state change.
- WRITE hit: data replaced, dirty set to 1, touch; rsp_hit=1, rsp_way=hit way.
- WRITE miss: no state change; rsp_hit=0; victim fields reported.
- FILL:
  - If the tag already hits: overwrite that way, dirty=req_dirty, touch; rsp_hit=1, rsp_victim_dirty=0.
  - Otherwise: write the victim way with valid=1, dirty=req_dirty, tag and data, then touch. rsp_way=victim, and the victim fields carry the evicted line (rsp_victim_dirty=0 if the victim was invalid).
- INVAL_ALL:
  - FSM IDLE -> SWEEP; req_ready=0 while in SWEEP.
  - Sweep counter steps sets 0..SETS-1, one set per cycle. Each step clears valid and dirty for all ways of that set and resets its ages to the reset pattern.
  - After set SETS-1, SWEEP -> IDLE; req_ready=1 on the next cycle.
  - One response (rsp_hit=0, all data fields 0) is issued the cycle after acceptance.
  - Total unavailability is SETS cycles.
- Reset during SWEEP: abort immediately; FSM returns to IDLE with everything invalid.
- Widths: tag width = ADDR_W - log2(SETS); ages are log2(WAYS) bits and are never allowed to wrap.

Decomposition:
- Package cache_pkg:
  - op enum cache_op_e {OP_READ, OP_WRITE, OP_FILL, OP_INVAL_ALL}.
  - FSM enum {IDLE, SWEEP}.
  - Helper localparams/functions for INDEX_W, TAG_W, WAY_W.
- Sub-module nway_lru_ctrl (params WAYS, SETS):
  - Holds the age array.
  - Outputs victim age per way for the indexed set.
  - Applies the touch or reset-pattern update.
- Hit compare, victim pick, arrays and FSM stay in the top level.

Test Plan:
- WAYS=2, SETS=32. After reset, READ 0x0123 -> next cycle rsp_valid=1, rsp_hit=0, rsp_way=0, rsp_victim_dirty=0; req_ready=1 throughout.
- FILL 0x0123 data 0xA5A5…, dirty=0, then READ 0x0123 -> rsp_hit=1, rsp_way=0, rsp_rdata=0xA5A5…
- FILL 0x0023 and 0x0043 (index 3, tags 1 and 2), then FILL 0x0063:
  - The third fill's response shows rsp_way=0 (the LRU way), rsp_victim_tag=1.
  - READ 0x0023 then misses.
- FILL 0x0023, then WRITE 0x0023 data 0x1, then FILL 0x0043 and FILL 0x0063 (both index 3):
  - The third fill evicts tag 1 with rsp_victim_dirty=1, rsp_victim_data=0x1.
- Back-to-back same-set requests: FILL 0x0005 followed immediately by READ 0x0005 -> the READ hits, with no stall.
- INVAL_ALL:
  - req_ready=0 for exactly 32 cycles; one response is issued.
  - Afterwards every READ misses.
  - Asserting rst at sweep cycle 10 returns req_ready=1 immediately after rst drops.

Source files
------------

// File: rtl/nway_cache_array_pkg.sv
// Shared types and width helpers for the N-way set-associative cache array.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_READ      = 2'd0,
        OP_WRITE     = 2'd1,
        OP_FILL      = 2'd2,
        OP_INVAL_ALL = 2'd3
    } cache_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } cache_state_e;

    function automatic int unsigned index_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned way_w(input int unsigned ways);
        return $clog2(ways);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
        return addr_w - $clog2(sets);
    endfunction

endpackage

// File: rtl/nway_cache_array_if.sv
// Request/response bundle between the L1 controller and the cache array.
interface nway_cache_array_if #(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 32,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 64
);
    import cache_pkg::*;

    localparam int unsigned WAY_W = way_w(WAYS);
    localparam int unsigned TAG_W = tag_w(ADDR_W, SETS);

    logic              req_valid;
    logic              req_ready;
    cache_op_e         req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_dirty;

    logic              rsp_valid;
    logic              rsp_hit;
    logic [WAY_W-1:0]  rsp_way;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_victim_dirty;
    logic [TAG_W-1:0]  rsp_victim_tag;
    logic [DATA_W-1:0] rsp_victim_data;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_dirty,
        input  req_ready,
        input  rsp_valid, rsp_hit, rsp_way, rsp_rdata,
        input  rsp_victim_dirty, rsp_victim_tag, rsp_victim_data
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_dirty,
        output req_ready,
        output rsp_valid, rsp_hit, rsp_way, rsp_rdata,
        output rsp_victim_dirty, rsp_victim_tag, rsp_victim_data
    );

endinterface

// File: rtl/nway_cache_array_lru_ctrl.sv
// True-LRU age store: one age per way per set, age 0 = most recently used.
module nway_lru_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned SETS = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [index_w(SETS)-1:0]               rd_idx,
    output logic [WAYS-1:0][way_w(WAYS)-1:0]       rd_age,
    input  logic                                   touch_en,
    input  logic [way_w(WAYS)-1:0]                 touch_way,
    input  logic                                   clr_en,
    input  logic [index_w(SETS)-1:0]               clr_idx
);

    localparam int unsigned WAY_W = way_w(WAYS);

    logic [WAY_W-1:0] age_q [SETS][WAYS];

    // Expose the ages of the currently indexed set.
    always_comb begin
        rd_age = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            rd_age[w] = age_q[rd_idx][w];
        end
    end

    // Reset/sweep restore the descending pattern; a touch moves one way to age 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(WAYS - 1 - w);
                end
            end
        end else if (clr_en) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                age_q[clr_idx][w] <= WAY_W'(WAYS - 1 - w);
            end
        end else if (touch_en) begin
            // Only ways younger than the touched one age, so the set stays a permutation.
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age_q[rd_idx][w] <= '0;
                end else if (rd_age[w] < rd_age[touch_way]) begin
                    age_q[rd_idx][w] <= rd_age[w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nway_cache_array.sv
// N-way set-associative tag/data array with true-LRU victim choice and bulk invalidate.
module nway_cache_array
    import cache_pkg::*;
#(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 32,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    nway_cache_array_if.slave  bus
);

    localparam int unsigned INDEX_W = index_w(SETS);
    localparam int unsigned TAG_W   = tag_w(ADDR_W, SETS);
    localparam int unsigned WAY_W   = way_w(WAYS);

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem [SETS][WAYS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];

    cache_state_e      state_q;
    logic [INDEX_W-1:0] sweep_q;
    logic              ready_q;

    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic [WAY_W-1:0]  rsp_way_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_vdirty_q;
    logic [TAG_W-1:0]  rsp_vtag_q;
    logic [DATA_W-1:0] rsp_vdata_q;

    logic [INDEX_W-1:0]           idx;
    logic [TAG_W-1:0]             req_tag;
    logic                         accept;
    logic [WAYS-1:0][WAY_W-1:0]   ages;
    logic                         hit;
    logic [WAY_W-1:0]             hit_way;
    logic [WAY_W-1:0]             victim_way;
    logic                         found_invalid;
    logic [WAY_W-1:0]             sel_way;
    logic                         vic_dirty;
    logic                         touch_en;

    assign idx     = bus.req_addr[INDEX_W-1:0];
    assign req_tag = bus.req_addr[ADDR_W-1:INDEX_W];
    assign accept  = bus.req_valid && ready_q;
    assign sel_way = hit ? hit_way : victim_way;
    assign vic_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];
    assign touch_en  = accept && ((bus.req_op == OP_FILL) ||
                       (((bus.req_op == OP_READ) || (bus.req_op == OP_WRITE)) && hit));

    nway_lru_ctrl #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx),
        .rd_age    (ages),
        .touch_en  (touch_en),
        .touch_way (sel_way),
        .clr_en    (state_q == SWEEP),
        .clr_idx   (sweep_q)
    );

    // Tag compare across the indexed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest way.
    always_comb begin
        victim_way    = '0;
        found_invalid = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_q[idx][w]) begin
                victim_way    = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (ages[w] == WAY_W'(WAYS - 1)) begin
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

    // Tag and data storage writes (not reset).
    always_ff @(posedge clk) begin
        if (accept && (bus.req_op == OP_WRITE) && hit) begin
            data_mem[idx][hit_way] <= bus.req_wdata;
        end
        if (accept && (bus.req_op == OP_FILL)) begin
            data_mem[idx][sel_way] <= bus.req_wdata;
            tag_mem[idx][sel_way]  <= req_tag;
        end
    end

    // Valid/dirty state: cleared by reset or sweep, set by WRITE hits and FILLs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (state_q == SWEEP) begin
            valid_q[sweep_q] <= '0;
            dirty_q[sweep_q] <= '0;
        end else if (accept) begin
            if ((bus.req_op == OP_WRITE) && hit) begin
                dirty_q[idx][hit_way] <= 1'b1;
            end else if (bus.req_op == OP_FILL) begin
                valid_q[idx][sel_way] <= 1'b1;
                dirty_q[idx][sel_way] <= bus.req_dirty;
            end
        end
    end

    // Bulk-invalidate sequencer; ready is registered and low for the whole sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sweep_q <= '0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && (bus.req_op == OP_INVAL_ALL)) begin
                        state_q <= SWEEP;
                        sweep_q <= '0;
                        ready_q <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (sweep_q == INDEX_W'(SETS - 1)) begin
                        state_q <= IDLE;
                        sweep_q <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Response registered from pre-update state at the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_rdata_q  <= '0;
            rsp_vdirty_q <= 1'b0;
            rsp_vtag_q   <= '0;
            rsp_vdata_q  <= '0;
        end else begin
            rsp_valid_q  <= accept;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_rdata_q  <= '0;
            rsp_vdirty_q <= 1'b0;
            rsp_vtag_q   <= '0;
            rsp_vdata_q  <= '0;
            if (accept && (bus.req_op != OP_INVAL_ALL)) begin
                rsp_hit_q <= hit;
                rsp_way_q <= sel_way;
                if (hit) begin
                    if (bus.req_op == OP_READ) begin
                        rsp_rdata_q <= data_mem[idx][hit_way];
                    end
                end else begin
                    rsp_vdirty_q <= vic_dirty;
                    rsp_vtag_q   <= tag_mem[idx][victim_way];
                    rsp_vdata_q  <= data_mem[idx][victim_way];
                end
            end
        end
    end

    assign bus.req_ready        = ready_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_hit          = rsp_hit_q;
    assign bus.rsp_way          = rsp_way_q;
    assign bus.rsp_rdata        = rsp_rdata_q;
    assign bus.rsp_victim_dirty = rsp_vdirty_q;
    assign bus.rsp_victim_tag   = rsp_vtag_q;
    assign bus.rsp_victim_data  = rsp_vdata_q;

endmodule
